// File: rtl/ex_mdu_pkg.sv
// Shared op codes, widths and divide-FSM encoding for the execute-stage MDU.
package ex_mdu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AOP_W  = 8;

    localparam logic [AOP_W-1:0] OP_MFHI  = 8'b00010000;
    localparam logic [AOP_W-1:0] OP_MTHI  = 8'b00010001;
    localparam logic [AOP_W-1:0] OP_MFLO  = 8'b00010010;
    localparam logic [AOP_W-1:0] OP_MTLO  = 8'b00010011;
    localparam logic [AOP_W-1:0] OP_MULT  = 8'b00011000;
    localparam logic [AOP_W-1:0] OP_MULTU = 8'b00011001;
    localparam logic [AOP_W-1:0] OP_DIV   = 8'b00011010;
    localparam logic [AOP_W-1:0] OP_DIVU  = 8'b00011011;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } div_state_e;

    // Two's-complement negate when en is set.
    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_mdu_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, DATA_W cycles per divide.
module ex_mdu_div_core
    import ex_mdu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o,
    output logic              ready_o
);

    localparam int unsigned CntW = $clog2(DATA_W);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W:0]   part;
    logic [DATA_W:0]   diff;

    // Next-state: load on start, otherwise one shift-subtract step while busy.
    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        // Dividend bits shift out of the quotient register into the partial remainder.
        part   = {rem_q, quo_q[DATA_W-1]};
        diff   = part - {1'b0, dvs_q};
        if (abort_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start_i) begin
            quo_d  = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!diff[DATA_W]) begin
                rem_d = diff[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_d = part[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
                busy_d = 1'b0;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Ready marks the final step; results are valid in the registers after this edge.
    assign ready_o     = busy_q && (cnt_q == LastCnt);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/ex_mdu.sv
// Execute-stage multiply/divide unit owning the HI/LO registers.
module ex_mdu
    import ex_mdu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [AOP_W-1:0]  aluop_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic              cancel_i,
    output logic              stallreq_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] hilo_rdata_o,
    output logic              div_busy_o
);

    div_state_e        state_q, state_d;
    logic              quo_neg_q, quo_neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic              zdiv_q, zdiv_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic                is_div, is_signed, div_start, div_abort, core_ready;
    logic [DATA_W-1:0]   core_quo, core_rem, quo_fix, rem_fix;
    logic [2*DATA_W-1:0] prod_s, prod_u;

    assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign is_signed = (aluop_i == OP_DIV);
    assign div_start = (state_q == StIdle) && is_div && !cancel_i && (reg2_i != '0);
    assign div_abort = cancel_i && (state_q != StIdle);

    // Sign-extended to full product width; the low 2*DATA_W bits are the signed product.
    assign prod_s = {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} * {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i};
    assign prod_u = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};

    ex_mdu_div_core u_div_core (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .abort_i     (div_abort),
        .dividend_i  (neg_if(reg1_i, is_signed && reg1_i[DATA_W-1])),
        .divisor_i   (neg_if(reg2_i, is_signed && reg2_i[DATA_W-1])),
        .quotient_o  (core_quo),
        .remainder_o (core_rem),
        .ready_o     (core_ready)
    );

    assign quo_fix = neg_if(core_quo, quo_neg_q);
    assign rem_fix = neg_if(core_rem, rem_neg_q);

    // Divide FSM next-state and stall request.
    always_comb begin
        state_d    = state_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        zdiv_d     = zdiv_q;
        stallreq_o = 1'b0;
        case (state_q)
            StIdle: begin
                if (is_div && !cancel_i) begin
                    stallreq_o = 1'b1;
                    if (reg2_i == '0) begin
                        state_d = StDone;
                        zdiv_d  = 1'b1;
                    end else begin
                        state_d   = StRun;
                        zdiv_d    = 1'b0;
                        quo_neg_d = is_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                        rem_neg_d = is_signed && reg1_i[DATA_W-1];
                    end
                end
            end
            StRun: begin
                if (cancel_i) begin
                    state_d = StIdle;
                end else begin
                    stallreq_o = 1'b1;
                    if (core_ready) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Never restarts here even though aluop_i still shows the divide.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // HI/LO next-state: MT*/MULT writes, divide completion; cancel suppresses all writes.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (!cancel_i) begin
            case (aluop_i)
                OP_MTHI:  hi_d = reg1_i;
                OP_MTLO:  lo_d = reg1_i;
                OP_MULT:  {hi_d, lo_d} = prod_s;
                OP_MULTU: {hi_d, lo_d} = prod_u;
                default:  ;
            endcase
            if ((state_q == StDone) && !zdiv_q) begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
        end
    end

    // State and architectural register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            zdiv_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            zdiv_q    <= zdiv_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // HI/LO read port for MFHI/MFLO.
    always_comb begin
        hilo_rdata_o = '0;
        if (aluop_i == OP_MFHI) begin
            hilo_rdata_o = hi_q;
        end else if (aluop_i == OP_MFLO) begin
            hilo_rdata_o = lo_q;
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign div_busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_ex_mdu.sv
// Directed scoreboard bench for ex_mdu.
module tb_ex_mdu;
    import ex_mdu_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [AOP_W-1:0]  aluop_i;
    logic [DATA_W-1:0] reg1_i, reg2_i;
    logic              cancel_i;
    logic              stallreq_o, div_busy_o;
    logic [DATA_W-1:0] hi_o, lo_o, hilo_rdata_o;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    ex_mdu dut (
        .clk          (clk),
        .rst          (rst),
        .aluop_i      (aluop_i),
        .reg1_i       (reg1_i),
        .reg2_i       (reg2_i),
        .cancel_i     (cancel_i),
        .stallreq_o   (stallreq_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .hilo_rdata_o (hilo_rdata_o),
        .div_busy_o   (div_busy_o)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            failed++;
            $error("FAIL sb_empty: got %h, no expected entry", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h required %h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        aluop_i = 8'h00;
        reg1_i  = '0;
        reg2_i  = '0;
    endtask

    // Present a divide, count stall cycles (bounded), then check completion and HI/LO.
    task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stall,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        aluop_i = op;
        reg1_i  = a;
        reg2_i  = b;
        push({tag, "_stall_cycles"}, 32'(exp_stall));
        push({tag, "_busy_done"}, 32'd1);
        push({tag, "_hi"}, exp_hi);
        push({tag, "_lo"}, exp_lo);
        push({tag, "_busy_after"}, 32'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stallreq_o) break;
            n++;
            // Operands must be ignored once the divide is running.
            if (n == 5) begin
                reg1_i = 32'h12345678;
                reg2_i = 32'h00000003;
            end
            tick();
        end
        check(32'(n));
        check({31'b0, div_busy_o});
        tick();
        idle_inputs();
        #1;
        check(hi_o);
        check(lo_o);
        check({31'b0, div_busy_o});
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        cancel_i = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst     = 1'b0;
        aluop_i = OP_MFHI;

        // Reset state.
        push("rst_hi", 32'h0);
        push("rst_lo", 32'h0);
        push("rst_stall", 32'h0);
        push("rst_busy", 32'h0);
        push("rst_rdata", 32'h0);
        #1;
        check(hi_o);
        check(lo_o);
        check({31'b0, stallreq_o});
        check({31'b0, div_busy_o});
        check(hilo_rdata_o);
        tick();

        // MULT -2 * 3.
        aluop_i = OP_MULT;
        reg1_i  = 32'hFFFFFFFE;
        reg2_i  = 32'd3;
        push("mult_stall", 32'h0);
        push("mult_hi", 32'hFFFFFFFF);
        push("mult_lo", 32'hFFFFFFFA);
        #1;
        check({31'b0, stallreq_o});
        tick();
        idle_inputs();
        check(hi_o);
        check(lo_o);

        // MULTU max * max.
        aluop_i = OP_MULTU;
        reg1_i  = 32'hFFFFFFFF;
        reg2_i  = 32'hFFFFFFFF;
        push("multu_hi", 32'hFFFFFFFE);
        push("multu_lo", 32'h00000001);
        tick();
        idle_inputs();
        check(hi_o);
        check(lo_o);

        // MTHI / MFHI, MTLO / MFLO, non-MF read.
        aluop_i = OP_MTHI;
        reg1_i  = 32'hDEADBEEF;
        push("mthi_stall", 32'h0);
        #1;
        check({31'b0, stallreq_o});
        tick();
        idle_inputs();
        aluop_i = OP_MFHI;
        push("mfhi_rdata", 32'hDEADBEEF);
        #1;
        check(hilo_rdata_o);
        tick();
        aluop_i = OP_MTLO;
        reg1_i  = 32'd5;
        tick();
        idle_inputs();
        aluop_i = OP_MFLO;
        push("mflo_rdata", 32'd5);
        #1;
        check(hilo_rdata_o);
        aluop_i = 8'h21;
        push("nonmf_rdata", 32'h0);
        #1;
        check(hilo_rdata_o);
        tick();

        // Cancel suppresses an MT write.
        aluop_i  = OP_MTHI;
        reg1_i   = 32'h00000099;
        cancel_i = 1'b1;
        push("cancel_mthi_hi", 32'hDEADBEEF);
        tick();
        cancel_i = 1'b0;
        idle_inputs();
        check(hi_o);

        // Cancel in IDLE blocks a divide start.
        aluop_i  = OP_DIV;
        reg1_i   = 32'd10;
        reg2_i   = 32'd2;
        cancel_i = 1'b1;
        push("cancel_idle_stall", 32'h0);
        push("cancel_idle_busy", 32'h0);
        push("cancel_idle_lo", 32'd5);
        #1;
        check({31'b0, stallreq_o});
        tick();
        cancel_i = 1'b0;
        idle_inputs();
        #1;
        check({31'b0, div_busy_o});
        check(lo_o);

        // Signed divide -7 / 2.
        run_div("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);

        // Zero divisor leaves HI/LO untouched.
        aluop_i = OP_MTHI;
        reg1_i  = 32'h11;
        tick();
        aluop_i = OP_MTLO;
        reg1_i  = 32'h22;
        tick();
        run_div("divu_zero", OP_DIVU, 32'd50, 32'd0, 1, 32'h11, 32'h22);

        // Signed overflow wraps.
        run_div("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);

        // Unsigned 100 / 7.
        run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);

        // Cancel in RUN.
        aluop_i = OP_MTHI;
        reg1_i  = 32'hAA;
        tick();
        aluop_i = OP_MTLO;
        reg1_i  = 32'hBB;
        tick();
        aluop_i = OP_DIVU;
        reg1_i  = 32'd100;
        reg2_i  = 32'd7;
        repeat (10) tick();
        cancel_i = 1'b1;
        push("cancel_run_stall", 32'h0);
        push("cancel_run_busy_pre", 32'h1);
        push("cancel_run_stall_next", 32'h0);
        push("cancel_run_busy_next", 32'h0);
        push("cancel_run_hi", 32'hAA);
        push("cancel_run_lo", 32'hBB);
        push("cancel_run_hi_late", 32'hAA);
        push("cancel_run_lo_late", 32'hBB);
        #1;
        check({31'b0, stallreq_o});
        check({31'b0, div_busy_o});
        tick();
        cancel_i = 1'b0;
        idle_inputs();
        #1;
        check({31'b0, stallreq_o});
        check({31'b0, div_busy_o});
        check(hi_o);
        check(lo_o);
        repeat (40) tick();
        check(hi_o);
        check(lo_o);

        // Reset mid-divide.
        aluop_i = OP_DIVU;
        reg1_i  = 32'd100;
        reg2_i  = 32'd7;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        push("rst_run_hi", 32'h0);
        push("rst_run_lo", 32'h0);
        push("rst_run_busy", 32'h0);
        push("rst_run_stall", 32'h0);
        push("rst_run_lo_late", 32'h0);
        #1;
        check(hi_o);
        check(lo_o);
        check({31'b0, div_busy_o});
        check({31'b0, stallreq_o});
        repeat (40) tick();
        check(lo_o);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Execute-stage multiply/divide unit, directly downstream of the decode stage.
- Consumes the decoded ALU op code and the two source operand values, and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and supplies the HI/LO read value for MFHI/MFLO.
- DIV/DIVU are iterative over multiple cycles. While they run, a stall request holds the PC and the decoded instruction stable.

Parameters:
- DATA_W, 32, operand/HI/LO width
- AOP_W, 8, ALU op code width (matches the decode AluOp bus)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- aluop_i  in  AOP_W  decoded ALU op code
- reg1_i  in  DATA_W  source operand 1 (rs value)
- reg2_i  in  DATA_W  source operand 2 (rt value)
- cancel_i  in  1  abort an in-flight divide (pipeline flush/exception)
- stallreq_o  out  1  request to hold PC/decode; combinational
- hi_o  out  DATA_W  current HI register
- lo_o  out  DATA_W  current LO register
- hilo_rdata_o  out  DATA_W  hi_o when MFHI, lo_o when MFLO, else 0; combinational
- div_busy_o  out  1  high while state is not IDLE

Behaviour:
- Op codes (shared defines):
  - MFHI 8'b00010000
  - MTHI 8'b00010001
  - MFLO 8'b00010010
  - MTLO 8'b00010011
  - MULT 8'b00011000
  - MULTU 8'b00011001
  - DIV 8'b00011010
  - DIVU 8'b00011011
  - Any other code: no HI/LO effect.
- Reset, sampled at the edge:
  - HI = 0, LO = 0, state = IDLE, counter = 0.
  - stallreq_o = 0, div_busy_o = 0, hilo_rdata_o = 0.
  - Reset overrides everything, including mid-divide.
- MTHI / MTLO: HI (respectively LO) <= reg1_i at the edge ending the cycle. No stall.
- MULT / MULTU:
  - Combinational 32x32 multiply to a 64-bit product; signed for MULT, unsigned for MULTU.
  - {HI,LO} <= product at the edge ending the same cycle. No stall.
- Reads: HI/LO writes are visible on hi_o/lo_o/hilo_rdata_o the cycle after the write edge. No same-cycle bypass is needed, because a single instruction is present per cycle.
- Divide state machine: IDLE -> RUN -> DONE -> IDLE.
  - IDLE with DIV/DIVU and reg2_i != 0:
    - stallreq_o = 1 combinationally.
    - At the edge: latch operand magnitudes and sign flags (signed only for DIV), counter = 0, go to RUN.
  - IDLE with DIV/DIVU and reg2_i == 0:
    - stallreq_o = 1, go to DONE with a zero-divide flag set.
    - HI/LO are left unchanged at completion.
  - RUN:
    - stallreq_o = 1.
    - One restoring shift-subtract step per cycle: 33-bit partial remainder, 32-bit quotient.
    - counter increments; on the edge where counter == 31, go to DONE.
  - DONE:
    - stallreq_o = 0, so the PC advances at this edge.
    - At this edge: LO <= quotient and HI <= remainder (unless the zero-divide flag is set); state -> IDLE.
    - DONE never restarts, even though aluop_i still shows DIV during this cycle.
  - Latency, non-zero divisor: presented in cycle 0, stall asserted for cycles 0..32 (33 cycles), DONE in cycle 33, HI/LO updated at edge 34.
  - Latency, zero divisor: stall for 1 cycle, DONE in cycle 1.
- Signed fix-up:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (two's-complement wrap, no trap).
- Operand capture: operands are latched at IDLE->RUN. Changes on reg1_i/reg2_i during RUN are ignored.
- cancel_i:
  - In RUN or DONE: next state IDLE, no HI/LO write, stallreq_o = 0 from that cycle.
  - In IDLE: blocks the start of a divide that cycle.
  - Suppresses MT*/MULT writes in the same cycle.
- MT*/MULT ops are never presented while the state is RUN, since the stall holds the decode stage; no special handling is required.

Decomposition:
- Shared defines: op codes above, DATA_W, AOP_W, plus the state encodings IDLE/RUN/DONE (2-bit).
- Sub-module div_core: iterative unsigned restoring divider.
  - Inputs: start, dividend, divisor, abort.
  - Outputs: quotient, remainder, ready.
- The sign fix-up, HI/LO registers and state machine stay in ex_mdu.

Test Plan:
- MULT, reg1_i = 0xFFFFFFFE (-2), reg2_i = 3 -> next cycle HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; stallreq_o stays 0.
- MULTU, 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV, reg1_i = -7 (0xFFFFFFF9), reg2_i = 2:
  - stallreq_o high for exactly 33 cycles, low in cycle 33.
  - After edge 34: LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1).
- DIVU with divisor 0, HI = 0x11, LO = 0x22 beforehand -> 1 stall cycle, HI/LO unchanged; DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Start DIVU 100/7, assert cancel_i in RUN cycle 10 -> stallreq_o = 0 next cycle, state IDLE, HI/LO unchanged. Repeat with rst instead -> HI = LO = 0.
- MTHI 0xDEADBEEF, then MFHI -> hilo_rdata_o = 0xDEADBEEF. MTLO 5, then MFLO -> 5. Any non-MF op -> hilo_rdata_o = 0.
